// File: rtl/reorder_buffer_if.sv
// Decode/dispatch, result-broadcast, operand-lookup and commit signals of the reorder buffer.
// The master side drives requests; the slave side is the ROB.
interface reorder_buffer_if #(
    parameter int unsigned TAG_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RF_WIDTH   = 5
);
    logic                  halt;
    logic                  flush;

    logic                  alloc_valid;
    logic                  alloc_hasRd;
    logic [RF_WIDTH-1:0]   alloc_rd;
    logic                  alloc_ready;
    logic [TAG_WIDTH-1:0]  destinationTag;

    logic                  broadcastDataAvailable;
    logic [TAG_WIDTH-1:0]  broadcastDestinationTag;
    logic [DATA_WIDTH-1:0] broadcastDestinationData;

    logic [TAG_WIDTH-1:0]  lookup_tag;
    logic                  lookup_done;
    logic [DATA_WIDTH-1:0] lookup_data;

    logic                  commit_valid;
    logic                  commit_hasRd;
    logic [RF_WIDTH-1:0]   commit_rd;
    logic [TAG_WIDTH-1:0]  commit_tag;
    logic [DATA_WIDTH-1:0] commit_data;

    modport master (
        output halt, flush,
        output alloc_valid, alloc_hasRd, alloc_rd,
        input  alloc_ready, destinationTag,
        output broadcastDataAvailable, broadcastDestinationTag, broadcastDestinationData,
        output lookup_tag,
        input  lookup_done, lookup_data,
        input  commit_valid, commit_hasRd, commit_rd, commit_tag, commit_data
    );

    modport slave (
        input  halt, flush,
        input  alloc_valid, alloc_hasRd, alloc_rd,
        output alloc_ready, destinationTag,
        input  broadcastDataAvailable, broadcastDestinationTag, broadcastDestinationData,
        input  lookup_tag,
        output lookup_done, lookup_data,
        output commit_valid, commit_hasRd, commit_rd, commit_tag, commit_data
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates rename tags, captures broadcast results,
// and retires completed entries in program order through a registered commit packet.
module reorder_buffer #(
    parameter int unsigned TAG_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RF_WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
    localparam int unsigned PTR_W = TAG_WIDTH + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      count;
    logic [TAG_WIDTH-1:0]  head_idx;
    logic [TAG_WIDTH-1:0]  tail_idx;
    logic [TAG_WIDTH-1:0]  bcast_idx;

    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      done;
    logic                  has_rd_q [DEPTH];
    logic [RF_WIDTH-1:0]   rd_q     [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];

    logic full;
    logic empty;
    logic do_alloc;
    logic do_bcast;
    logic do_commit;

    assign head_idx  = head[TAG_WIDTH-1:0];
    assign tail_idx  = tail[TAG_WIDTH-1:0];
    assign bcast_idx = bus.broadcastDestinationTag;
    assign count     = tail - head;
    assign full      = (count == PTR_W'(DEPTH));
    assign empty     = (count == '0);

    assign do_alloc  = bus.alloc_valid & ~full & ~bus.halt & ~bus.flush;
    assign do_bcast  = bus.broadcastDataAvailable & ~bus.flush & busy[bcast_idx] & ~done[bcast_idx];
    assign do_commit = ~bus.halt & ~bus.flush & ~empty & busy[head_idx] & done[head_idx];

    assign bus.alloc_ready    = ~full;
    assign bus.destinationTag = tail_idx;
    assign bus.lookup_done    = busy[bus.lookup_tag] & done[bus.lookup_tag];
    assign bus.lookup_data    = data_q[bus.lookup_tag];

    // Head/tail pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_commit) head <= head + PTR_W'(1);
            if (do_alloc)  tail <= tail + PTR_W'(1);
        end
    end

    // Entry status; commit, alloc and broadcast never target the same index in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            done <= '0;
        end else if (bus.flush) begin
            busy <= '0;
            done <= '0;
        end else begin
            if (do_commit) begin
                busy[head_idx] <= 1'b0;
                done[head_idx] <= 1'b0;
            end
            if (do_alloc) begin
                busy[tail_idx] <= 1'b1;
                done[tail_idx] <= 1'b0;
            end
            if (do_bcast) done[bcast_idx] <= 1'b1;
        end
    end

    // Entry payload needs no reset: it is only observed while the entry is busy and done.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            has_rd_q[tail_idx] <= bus.alloc_hasRd;
            rd_q[tail_idx]     <= bus.alloc_rd;
            data_q[tail_idx]   <= '0;
        end
        if (do_bcast) data_q[bcast_idx] <= bus.broadcastDestinationData;
    end

    // Registered commit packet; fields hold between retire pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.commit_valid <= 1'b0;
            bus.commit_hasRd <= 1'b0;
            bus.commit_rd    <= '0;
            bus.commit_tag   <= '0;
            bus.commit_data  <= '0;
        end else begin
            bus.commit_valid <= do_commit;
            if (do_commit) begin
                bus.commit_hasRd <= has_rd_q[head_idx];
                bus.commit_rd    <= rd_q[head_idx];
                bus.commit_tag   <= head_idx;
                bus.commit_data  <= data_q[head_idx];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, every cycle
// compared against an in-order queue model of the buffer.
module tb_reorder_buffer;
    localparam int unsigned TW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .RF_WIDTH(RW)) bus ();
    reorder_buffer #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .RF_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic          has_rd;
        logic [RW-1:0] rd;
        logic          done;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [TW-1:0] next_tag;
    logic          exp_cv;
    logic          exp_chr;
    logic [RW-1:0] exp_crd;
    logic [TW-1:0] exp_ctag;
    logic [DW-1:0] exp_cdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_tag  = '0;
        exp_cv    = 1'b0;
        exp_chr   = 1'b0;
        exp_crd   = '0;
        exp_ctag  = '0;
        exp_cdata = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check commit packet.
    task automatic step(input logic h, input logic f, input logic av, input logic ahr,
                        input logic [RW-1:0] ard, input logic bv, input logic [TW-1:0] bt,
                        input logic [DW-1:0] bd, input logic [TW-1:0] lt);
        logic ready;
        logic l_done;
        logic [DW-1:0] l_data;
        ent_t e;
        @(negedge clk);
        bus.halt = h;
        bus.flush = f;
        bus.alloc_valid = av;
        bus.alloc_hasRd = ahr;
        bus.alloc_rd = ard;
        bus.broadcastDataAvailable = bv;
        bus.broadcastDestinationTag = bt;
        bus.broadcastDestinationData = bd;
        bus.lookup_tag = lt;
        #1;
        ready = (q.size() < 128);
        l_done = 1'b0;
        l_data = '0;
        foreach (q[i]) if (q[i].tag == lt && q[i].done) begin
            l_done = 1'b1;
            l_data = q[i].data;
        end
        check("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
        check("dest_tag", 64'(bus.destinationTag), 64'(next_tag));
        check("lookup_done", 64'(bus.lookup_done), 64'(l_done));
        if (l_done) check("lookup_data", 64'(bus.lookup_data), 64'(l_data));

        exp_cv = 1'b0;
        if (f) begin
            q.delete();
            next_tag = '0;
        end else begin
            if (!h && q.size() > 0 && q[0].done) begin
                e = q.pop_front();
                exp_cv = 1'b1;
                exp_chr = e.has_rd;
                exp_crd = e.rd;
                exp_ctag = e.tag;
                exp_cdata = e.data;
            end
            if (bv) foreach (q[i]) if (q[i].tag == bt && !q[i].done) begin
                q[i].done = 1'b1;
                q[i].data = bd;
            end
            if (av && ready && !h) begin
                e.tag = next_tag;
                e.has_rd = ahr;
                e.rd = ard;
                e.done = 1'b0;
                e.data = '0;
                q.push_back(e);
                next_tag = next_tag + 7'd1;
            end
        end
        @(posedge clk);
        #1;
        check("commit_valid", 64'(bus.commit_valid), 64'(exp_cv));
        check("commit_hasRd", 64'(bus.commit_hasRd), 64'(exp_chr));
        check("commit_rd", 64'(bus.commit_rd), 64'(exp_crd));
        check("commit_tag", 64'(bus.commit_tag), 64'(exp_ctag));
        check("commit_data", 64'(bus.commit_data), 64'(exp_cdata));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic alloc(input logic [RW-1:0] rd);
        step(1'b0, 1'b0, 1'b1, 1'b1, rd, 1'b0, '0, '0, '0);
    endtask

    task automatic bcast(input logic h, input logic [TW-1:0] t, input logic [DW-1:0] d);
        step(h, 1'b0, 1'b0, 1'b0, '0, 1'b1, t, d, t);
    endtask

    task automatic flush_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        bus.halt = 1'b0;
        bus.flush = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_hasRd = 1'b0;
        bus.alloc_rd = '0;
        bus.broadcastDataAvailable = 1'b0;
        bus.broadcastDestinationTag = '0;
        bus.broadcastDestinationData = '0;
        bus.lookup_tag = '0;
        model_reset();

        #1;
        check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst_dest_tag", 64'(bus.destinationTag), 64'd0);
        check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        check("rst_commit_data", 64'(bus.commit_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // In-order retire of out-of-order results
        alloc(5'd3);
        alloc(5'd5);
        alloc(5'd7);
        bcast(1'b0, 7'd2, 32'hC);
        bcast(1'b0, 7'd0, 32'hA);
        check("first_pulse_not_early", 64'(bus.commit_valid), 64'd0);
        bcast(1'b0, 7'd1, 32'hB);
        check("c0_tag", 64'(bus.commit_tag), 64'd0);
        check("c0_data", 64'(bus.commit_data), 64'hA);
        idle();
        check("c1_rd", 64'(bus.commit_rd), 64'd5);
        check("c1_data", 64'(bus.commit_data), 64'hB);
        idle();
        check("c2_tag", 64'(bus.commit_tag), 64'd2);
        check("c2_data", 64'(bus.commit_data), 64'hC);
        idle();

        // Fill to full, overflow attempt, then retire one and wrap the tail
        flush_cycle();
        for (int i = 0; i < 128; i++) alloc(5'(i));
        check("full_ready", 64'(bus.alloc_ready), 64'd0);
        alloc(5'd31);
        bcast(1'b0, 7'd0, 32'h1234);
        idle();
        check("wrap_ready", 64'(bus.alloc_ready), 64'd1);
        check("wrap_tag", 64'(bus.destinationTag), 64'd0);
        alloc(5'd9);
        check("refull_ready", 64'(bus.alloc_ready), 64'd0);

        // Halt freezes commit and alloc but not broadcast capture
        flush_cycle();
        alloc(5'd1);
        alloc(5'd2);
        bcast(1'b0, 7'd0, 32'h11);
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 7'd1, 32'h22, 7'd1);
        bcast(1'b1, 7'd5, 32'h33);
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0, '0, '0, 7'd0);
        check("halt_no_alloc", 64'(bus.destinationTag), 64'd2);
        idle();
        check("rel_c0", 64'(bus.commit_tag), 64'd0);
        idle();
        check("rel_c1_data", 64'(bus.commit_data), 64'h22);

        // Flush with four entries in flight, then a stale broadcast
        flush_cycle();
        for (int i = 0; i < 4; i++) alloc(5'(10 + i));
        flush_cycle();
        check("flush_ready", 64'(bus.alloc_ready), 64'd1);
        check("flush_tag", 64'(bus.destinationTag), 64'd0);
        check("flush_cv", 64'(bus.commit_valid), 64'd0);
        bcast(1'b0, 7'd2, 32'hDEAD);
        idle();
        bus.lookup_tag = 7'd2;
        #1;
        check("stale_lookup", 64'(bus.lookup_done), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [TW-1:0] bt;
            logic          bv;
            logic [TW-1:0] lt;
            bt = 7'($urandom);
            if (q.size() > 0 && ($urandom % 4) != 0) bt = q[$urandom_range(q.size() - 1)].tag;
            bv = ($urandom % 3) != 0;
            lt = (q.size() > 0 && ($urandom % 2) != 0) ? q[$urandom_range(q.size() - 1)].tag : 7'($urandom);
            step(($urandom % 10) == 0, ($urandom % 200) == 0, ($urandom % 100) < 55,
                 1'($urandom), 5'($urandom), bv, bt, 32'($urandom), lt);
        end

        // Asynchronous reset while a commit pulse is on the bus
        flush_cycle();
        alloc(5'd17);
        bcast(1'b0, 7'd0, 32'h5A5A);
        idle();
        check("pre_rst_cv", 64'(bus.commit_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_cv", 64'(bus.commit_valid), 64'd0);
        check("arst_rd", 64'(bus.commit_rd), 64'd0);
        check("arst_data", 64'(bus.commit_data), 64'd0);
        check("arst_ready", 64'(bus.alloc_ready), 64'd1);
        check("arst_tag", 64'(bus.destinationTag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        alloc(5'd8);
        check("post_rst_tag", 64'(bus.destinationTag), 64'd1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
